// File: rtl/result_buffer_bank.sv
// result_buffer_bank: 2048 x 512-bit result row buffer feeding the save stage.
// Compute engines write or lane-wise accumulate rows through a three-stage
// write pipeline; the save stage reads rows through a fixed 2-cycle read port.
// A clear sequencer zeroes the whole bank between layers.
`timescale 1ns/1ps

module result_buffer_bank #(
   parameter int C_DATA_WIDTH = 512,
   parameter int C_ADDR_WIDTH = 11,
   parameter int C_LANE_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    ap_rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic                    wr_acc,
   input  logic [C_ADDR_WIDTH-1:0] wr_addr,
   input  logic [C_DATA_WIDTH-1:0] wr_data,
   input  logic                    rd_avalid,
   input  logic [C_ADDR_WIDTH-1:0] rd_addr,
   output logic                    rd_valid,
   output logic [C_DATA_WIDTH-1:0] rd_data,
   input  logic                    clear_start,
   output logic                    clear_done,
   output logic                    busy
);

   localparam int C_LANES = C_DATA_WIDTH / C_LANE_WIDTH;
   localparam int C_DEPTH = 2 ** C_ADDR_WIDTH;
   localparam logic [C_ADDR_WIDTH-1:0] C_CNT_ONE = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t state;

   // Two replicated copies sharing one commit port: R feeds the save stage,
   // W feeds the accumulate lookups so they never compete for a read port.
   logic [C_DATA_WIDTH-1:0] mem_r [C_DEPTH];
   logic [C_DATA_WIDTH-1:0] mem_w [C_DEPTH];
   logic [C_DATA_WIDTH-1:0] mem_r_q;
   logic [C_DATA_WIDTH-1:0] mem_w_q;

   logic                    wr_accept;
   logic                    e1_valid;
   logic                    e1_acc;
   logic [C_ADDR_WIDTH-1:0] e1_addr;
   logic [C_DATA_WIDTH-1:0] e1_data;
   logic                    e2_valid;
   logic [C_ADDR_WIDTH-1:0] e2_addr;
   logic [C_DATA_WIDTH-1:0] e2_data;
   logic [C_DATA_WIDTH-1:0] old_row;
   logic [C_DATA_WIDTH-1:0] e1_result;

   logic                    commit_en;
   logic [C_ADDR_WIDTH-1:0] commit_addr;
   logic [C_DATA_WIDTH-1:0] commit_data;
   logic [C_ADDR_WIDTH-1:0] clr_cnt;

   logic                    rd_v0;
   logic                    rd_v1;
   logic [C_DATA_WIDTH-1:0] rd_p1;

   assign wr_accept = wr_valid && wr_ready;
   assign busy      = (state != IDLE) || e1_valid || e2_valid;

   // Commit port mux: the clear counter owns it in CLEAR (pipeline is drained
   // by then), otherwise the E2 stage; writes are suppressed while in reset.
   always_comb begin
      commit_en   = 1'b0;
      commit_addr = e2_addr;
      commit_data = e2_data;
      if (state == CLEAR) begin
         commit_en   = ap_rst_n;
         commit_addr = clr_cnt;
         commit_data = '0;
      end else if (e2_valid) begin
         commit_en   = ap_rst_n;
      end
   end

   // Storage: commit into both copies; copy R read is read-first so a row
   // committed on the same edge as a read request returns the older contents.
   always_ff @(posedge aclk) begin
      if (commit_en) begin
         mem_r[commit_addr] <= commit_data;
         mem_w[commit_addr] <= commit_data;
      end
      if (rd_avalid) begin
         mem_r_q <= mem_r[rd_addr];
      end
   end

   // Copy W lookup for the accept cycle; a commit landing on the same edge to
   // the same row is bypassed so a write two cycles older is never missed.
   always_ff @(posedge aclk) begin
      if (commit_en && (commit_addr == wr_addr)) begin
         mem_w_q <= commit_data;
      end else begin
         mem_w_q <= mem_w[wr_addr];
      end
   end

   // E1 merge: take the E2 result when it targets the same row, otherwise the
   // copy W row, then add lane by lane modulo 2**C_LANE_WIDTH when accumulating.
   always_comb begin
      old_row   = (e2_valid && (e2_addr == e1_addr)) ? e2_data : mem_w_q;
      e1_result = e1_data;
      if (e1_acc) begin
         for (int i = 0; i < C_LANES; i++) begin
            e1_result[i*C_LANE_WIDTH +: C_LANE_WIDTH] =
               old_row[i*C_LANE_WIDTH +: C_LANE_WIDTH] +
               e1_data[i*C_LANE_WIDTH +: C_LANE_WIDTH];
         end
      end
   end

   // Write pipeline registers: accept -> E1 -> E2 -> commit, order preserved.
   always_ff @(posedge aclk) begin
      if (wr_accept) begin
         e1_acc  <= wr_acc;
         e1_addr <= wr_addr;
         e1_data <= wr_data;
      end
      if (e1_valid) begin
         e2_addr <= e1_addr;
         e2_data <= e1_result;
      end
      if (!ap_rst_n) begin
         e1_valid <= 1'b0;
         e2_valid <= 1'b0;
      end else begin
         e1_valid <= wr_accept;
         e2_valid <= e1_valid;
      end
   end

   // Clear sequencer with registered wr_ready/clear_done; DRAIN leaves as soon
   // as E1 is empty because the last E2 commit lands on that same edge.
   always_ff @(posedge aclk) begin
      if (!ap_rst_n) begin
         state      <= IDLE;
         wr_ready   <= 1'b1;
         clear_done <= 1'b0;
         clr_cnt    <= '0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_start) begin
                  state    <= DRAIN;
                  wr_ready <= 1'b0;
               end
            end
            DRAIN: begin
               if (!e1_valid) begin
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               if (clr_cnt == '1) begin
                  state      <= FIN;
                  clear_done <= 1'b1;
                  clr_cnt    <= '0;
               end else begin
                  clr_cnt <= clr_cnt + C_CNT_ONE;
               end
            end
            FIN: begin
               state    <= IDLE;
               wr_ready <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               wr_ready <= 1'b1;
            end
         endcase
      end
   end

   // Read pipeline: memory read, one staging register, then the output
   // register, which holds its last value while no read is returning.
   always_ff @(posedge aclk) begin
      if (rd_v0) begin
         rd_p1 <= mem_r_q;
      end
      if (!ap_rst_n) begin
         rd_v0    <= 1'b0;
         rd_v1    <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_v0    <= rd_avalid;
         rd_v1    <= rd_v0;
         rd_valid <= rd_v1;
         if (rd_v1) begin
            rd_data <= rd_p1;
         end
      end
   end

endmodule

// File: tb/tb_result_buffer_bank.sv
// tb_result_buffer_bank: table-driven write/accumulate vectors plus
// hand-written sequences for forwarding, read ordering, clear and reset.
// Read expectations go into a scoreboard queue with their due cycle.
`timescale 1ns/1ps

module tb_result_buffer_bank;

   localparam int DW = 512;
   localparam int AW = 11;
   localparam int LW = 32;
   localparam int NL = DW / LW;
   localparam int NV = 9;

   logic          aclk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_acc = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_avalid = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          clear_start = 1'b0;
   logic          wr_ready;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          clear_done;
   logic          busy;

   typedef struct {
      logic          acc;
      logic [AW-1:0] addr;
      logic [31:0]   lane0;
      logic [31:0]   rest;
      logic [31:0]   exp_lane0;
      logic [31:0]   exp_rest;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
      string         name;
   } sb_t;

   vec_t vecs [NV];
   sb_t  sbq [$];
   sb_t  mon_item;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_pulses = 0;
   int ready_leaks = 0;
   bit watch_ready = 1'b0;

   result_buffer_bank dut (
      .aclk        (aclk),
      .ap_rst_n    (ap_rst_n),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_acc      (wr_acc),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_avalid   (rd_avalid),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .clear_start (clear_start),
      .clear_done  (clear_done),
      .busy        (busy)
   );

   // Free-running clock and edge counter used for read due-cycle bookkeeping.
   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   // Monitor on the falling edge: count clear_done pulses, catch wr_ready
   // leaking high during a clear, and score every returning read.
   always @(negedge aclk) begin
      if (clear_done) done_pulses++;
      if (watch_ready && wr_ready) ready_leaks++;
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
         mon_item = sbq.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL %s: read not returned by cycle %0d (now %0d)", mon_item.name, mon_item.due, cyc);
      end
      if (rd_valid) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_rd_valid: rd_valid=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_item = sbq.pop_front();
            if (mon_item.due != cyc || rd_data !== mon_item.data) begin
               errors++;
               $display("[TB] FAIL %s: cycle %0d data %h, required cycle %0d data %h", mon_item.name, cyc, rd_data, mon_item.due, mon_item.data);
            end
         end
      end
   end

   // Watchdog so the bench always ends even if the DUT wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [DW-1:0] makeRow(input logic [31:0] l0, input logic [31:0] rest);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < NL; i++) r[i*LW +: LW] = (i == 0) ? l0 : rest;
      return r;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input string name, input bit wv, input bit acc, input logic [AW-1:0] waddr,
                                input logic [DW-1:0] wdata, input bit rv, input logic [AW-1:0] raddr,
                                input logic [DW-1:0] rexp, input bit cs);
      sb_t it;
      if (wv) checkOutput({name, "_wr_ready"}, wr_ready, 1);
      wr_valid    = wv;
      wr_acc      = acc;
      wr_addr     = waddr;
      wr_data     = wdata;
      rd_avalid   = rv;
      rd_addr     = raddr;
      clear_start = cs;
      if (rv) begin
         it.data = rexp;
         it.due  = cyc + 3;
         it.name = name;
         sbq.push_back(it);
      end
      tick();
      wr_valid    = 1'b0;
      rd_avalid   = 1'b0;
      clear_start = 1'b0;
   endtask

   task automatic writeRow(input string name, input bit acc, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      applyStimulus(name, 1'b1, acc, addr, data, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic readRow(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] expected);
      applyStimulus(name, 1'b0, 1'b0, '0, '0, 1'b1, addr, expected, 1'b0);
   endtask

   task automatic drainReads();
      for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
      checkOutput("reads_drained", sbq.size() == 0, 1);
      sbq.delete();
   endtask

   task automatic waitClearDone(input string name, input int bound);
      int start;
      int n;
      start = done_pulses;
      n = 0;
      while (done_pulses == start && n < bound) begin
         tick();
         n++;
      end
      watch_ready = 1'b0;
      checkOutput({name, "_done_seen"}, done_pulses != start, 1);
      idle(5);
      checkOutput({name, "_done_once"}, done_pulses - start, 1);
      checkOutput({name, "_ready_back"}, wr_ready, 1);
   endtask

   initial begin
      logic [AW-1:0] zero_rows [9];
      int base;

      vecs[0] = '{1'b0, 11'd5,    32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
      vecs[1] = '{1'b1, 11'd5,    32'h00000002, 32'h00000002, 32'h00000003, 32'h00000003};
      vecs[2] = '{1'b0, 11'd7,    32'hFFFFFFFF, 32'h11111111, 32'hFFFFFFFF, 32'h11111111};
      vecs[3] = '{1'b1, 11'd7,    32'h00000001, 32'h00000000, 32'h00000000, 32'h11111111};
      vecs[4] = '{1'b1, 11'd7,    32'h00000005, 32'hEEEEEEEF, 32'h00000005, 32'h00000000};
      vecs[5] = '{1'b0, 11'd2047, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
      vecs[6] = '{1'b0, 11'd0,    32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
      vecs[7] = '{1'b1, 11'd0,    32'h00000001, 32'h00000010, 32'h12345679, 32'h9ABCDF00};
      vecs[8] = '{1'b0, 11'd2040, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A};
      zero_rows = '{11'd0, 11'd3, 11'd5, 11'd7, 11'd9, 11'd20, 11'd21, 11'd2040, 11'd2047};

      $display("[TB] reset");
      ap_rst_n = 1'b0;
      idle(3);
      ap_rst_n = 1'b1;
      tick();
      checkOutput("rst_wr_ready", wr_ready, 1);
      checkOutput("rst_rd_valid", rd_valid, 0);
      checkOutput("rst_rd_data", rd_data, 0);
      checkOutput("rst_clear_done", clear_done, 0);
      checkOutput("rst_busy", busy, 0);

      $display("[TB] initial clear");
      applyStimulus("clr1", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      checkOutput("clr1_wr_ready_drop", wr_ready, 0);
      checkOutput("clr1_busy", busy, 1);
      watch_ready = 1'b1;
      waitClearDone("clr1", 2200);
      checkOutput("clr1_ready_leaks", ready_leaks, 0);

      $display("[TB] write/accumulate vectors");
      for (int i = 0; i < NV; i++) begin
         writeRow($sformatf("vec%0d", i), vecs[i].acc, vecs[i].addr, makeRow(vecs[i].lane0, vecs[i].rest));
         checkOutput($sformatf("vec%0d_busy_high", i), busy, 1);
         idle(2);
         checkOutput($sformatf("vec%0d_busy_low", i), busy, 0);
         readRow($sformatf("vec%0d_read", i), vecs[i].addr, makeRow(vecs[i].exp_lane0, vecs[i].exp_rest));
      end
      drainReads();
      idle(2);
      checkOutput("hold_rd_valid", rd_valid, 0);
      checkOutput("hold_rd_data", rd_data, makeRow(vecs[NV-1].exp_lane0, vecs[NV-1].exp_rest));

      $display("[TB] accumulate forwarding");
      writeRow("fwd0", 1'b1, 11'd9, makeRow(32'h1, 32'h1));
      writeRow("fwd1", 1'b1, 11'd9, makeRow(32'h2, 32'h2));
      writeRow("fwd2", 1'b1, 11'd9, makeRow(32'h3, 32'h3));
      writeRow("fwd3", 1'b1, 11'd9, makeRow(32'h4, 32'h4));
      idle(2);
      readRow("fwd_b2b", 11'd9, makeRow(32'hA, 32'hA));
      writeRow("gap0", 1'b1, 11'd9, makeRow(32'h10, 32'h10));
      idle(1);
      writeRow("gap1", 1'b1, 11'd9, makeRow(32'h10, 32'h10));
      idle(2);
      readRow("fwd_gap", 11'd9, makeRow(32'h2A, 32'h2A));
      drainReads();

      $display("[TB] read ordering against writes");
      writeRow("ord_w", 1'b0, 11'd3, makeRow(32'h33333333, 32'h33333333));
      readRow("ord_t1_old", 11'd3, '0);
      readRow("ord_t2_old", 11'd3, '0);
      readRow("ord_t3_new", 11'd3, makeRow(32'h33333333, 32'h33333333));
      drainReads();

      $display("[TB] clear with writes in flight");
      writeRow("cif_w20", 1'b0, 11'd20, makeRow(32'h20202020, 32'h20202020));
      applyStimulus("cif_w21", 1'b1, 1'b0, 11'd21, makeRow(32'h21212121, 32'h21212121), 1'b0, '0, '0, 1'b1);
      checkOutput("cif_wr_ready_drop", wr_ready, 0);
      ready_leaks = 0;
      watch_ready = 1'b1;
      idle(1000);
      readRow("cif_mid_row0", 11'd0, '0);
      readRow("cif_mid_row2047", 11'd2047, makeRow(32'hDEADBEEF, 32'hCAFEF00D));
      drainReads();
      waitClearDone("cif", 2200);
      checkOutput("cif_ready_leaks", ready_leaks, 0);
      for (int i = 0; i < 9; i++) readRow($sformatf("cif_zero_row%0d", zero_rows[i]), zero_rows[i], '0);
      drainReads();

      $display("[TB] reset during clear");
      writeRow("rmc_w0", 1'b0, 11'd0, makeRow(32'h0F0F0F0F, 32'hF0F0F0F0));
      writeRow("rmc_w2040", 1'b0, 11'd2040, makeRow(32'hA5A5A5A5, 32'h5A5A5A5A));
      idle(3);
      applyStimulus("rmc_clr", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      idle(100);
      base = done_pulses;
      ap_rst_n = 1'b0;
      tick();
      checkOutput("rmc_wr_ready", wr_ready, 1);
      checkOutput("rmc_rd_valid", rd_valid, 0);
      checkOutput("rmc_busy", busy, 0);
      checkOutput("rmc_clear_done", clear_done, 0);
      ap_rst_n = 1'b1;
      idle(2200);
      checkOutput("rmc_no_done", done_pulses - base, 0);
      readRow("rmc_row0_zeroed", 11'd0, '0);
      readRow("rmc_row2040_kept", 11'd2040, makeRow(32'hA5A5A5A5, 32'h5A5A5A5A));
      drainReads();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_buffer_bank.md
# result_buffer_bank

On-chip result buffer bank that sits directly upstream of the save stage: compute engines write or accumulate 512-bit rows into it, and the save stage streams rows out through a fixed-latency read port. The read port uses the avalid/addr to valid/data handshake the save stage expects. The write port supports plain writes and lane-wise 32-bit accumulation with in-flight forwarding. A clear sequencer zeroes the whole bank between layers.

## Interface
- C_DATA_WIDTH, 512, row width in bits
- C_ADDR_WIDTH, 11, row address width; depth = 2**C_ADDR_WIDTH = 2048
- C_LANE_WIDTH, 32, accumulate lane width; lanes = C_DATA_WIDTH/C_LANE_WIDTH = 16

Ports:
- aclk  in  1  sole clock; everything is on aclk
- ap_rst_n  in  1  reset, synchronous, active-low
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_acc  in  1  1 = add wr_data lane-wise to stored row; 0 = overwrite
- wr_addr  in  C_ADDR_WIDTH  write row
- wr_data  in  C_DATA_WIDTH  write payload
- rd_avalid  in  1  read request (no backpressure; always accepted)
- rd_addr  in  C_ADDR_WIDTH  read row
- rd_valid  out  1  read data valid
- rd_data  out  C_DATA_WIDTH  read data
- clear_start  in  1  single-cycle pulse; zero the whole bank
- clear_done  out  1  single-cycle pulse when clear completes
- busy  out  1  high while the FSM is not IDLE or the write pipeline is non-empty

## Operation
- Storage: two replicated 1R1W copies with a shared write port. Copy R serves rd_*. Copy W serves accumulate reads. Internal read latency is 1 cycle (registered output).
- Write pipeline (all writes, plain or acc, use it so ordering is preserved):
  - P0: the accept cycle. Register addr/data/acc into E1 and present addr to copy W.
  - E1: old row = forwarded value if E2 holds the same addr with valid, else copy W output. Result = acc ? lane-wise (old + data) : data. Register into E2.
  - E2: commit result to both copies at the end of this cycle.
- Forwarding covers back-to-back accumulates to one row. E1 must see the E2 result, not stale memory. A write accepted in cycle t is visible to an internal E1 lookup of a write accepted in t+1.
- Lane add: each 32-bit lane is added independently, modulo 2**32. No carry between lanes, no saturation.
- Read port: no forwarding from the write pipeline. A read issued in cycle t returns the contents committed by writes accepted in cycle ≤ t-3. It returns older contents for writes accepted in t-2..t.
- FSM states:
  - IDLE: wr_ready=1. On clear_start go to DRAIN.
  - DRAIN: wr_ready=0. Wait until E1 and E2 are empty, then go to CLEAR.
  - CLEAR: wr_ready=0. An 11-bit counter writes zero rows 0..2047, one per cycle, via the commit port. After row 2047, go to FIN.
  - FIN: pulse clear_done for 1 cycle, then go to IDLE.
- clear_start outside IDLE is ignored.
- The read port stays operational in all states. Reads during CLEAR return a mix of old and zeroed rows according to the counter position.
- Reset: E1/E2 valids cleared, FSM to IDLE, counter 0. Memory contents are not reset; undefined until the first clear. Reset during CLEAR aborts the clear and leaves the bank partially zeroed.
- Reset values: wr_ready=1 (first cycle after reset deassert), rd_valid=0, rd_data=0, clear_done=0, busy=0.

## Timing
- Read latency is exactly 2 cycles. rd_avalid sampled at edge t gives rd_valid=1 with data for the cycle after edge t+2. Full throughput is 1 read per cycle.
- rd_valid is deasserted in any cycle with no matching request 2 cycles earlier. rd_data holds its last value when rd_valid=0.
- Write throughput is 1 per cycle in IDLE. Commit occurs 2 cycles after accept.
- wr_ready is a registered function of FSM state only. It drops the cycle after clear_start is sampled in IDLE.
- Clear duration from clear_start to clear_done is drain (0-2 cycles) + 2048 + 1 cycles.
- A simultaneous clear_start and accepted write in the same IDLE cycle: the write is accepted and completes in DRAIN before clearing begins.
- busy rises the cycle after any accepted write or clear_start. It falls when IDLE is reached and the pipeline is empty.

## Test plan
- Clear, then write row 5 = lanes all 0x00000001, then read row 5 three cycles later -> rd_valid 2 cycles after request, data all 0x00000001.
- 4 back-to-back acc writes to row 9 (lanes 0x1,0x2,0x3,0x4) after clear, read later -> every lane 0x0000000A; this proves forwarding.
- Acc of 0x00000001 onto a lane holding 0xFFFFFFFF -> that lane is 0x00000000 and the neighbouring lane is unchanged.
- Write row 3 at cycle t, read row 3 at t+1 -> old data; read at t+3 -> new data.
- clear_start while 2 writes are in flight -> the writes commit, wr_ready=0 for the whole clear, clear_done pulses once ~2050 cycles later, all rows read 0. Reads during clear show zeros below the counter position.
- Assert ap_rst_n=0 mid-CLEAR -> next cycle FSM IDLE, wr_ready=1, rd_valid=0, clear_done never pulses.
